// File: rtl/alu_writeback.sv
// alu_writeback: writeback stage behind the ALU and bit-manipulation units.
// Buffers up to two results and retires them in order to the register-file
// write port. The {N,V,C,Z} status register changes only when a result retires.
// Optional macro WB_BYPASS_EN adds byp_* ports that forward the youngest
// buffered entry.
module alu_writeback #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_flag_we,
  input  logic              in_is_bitmanip,
  input  logic              in_flag_z,
  input  logic              in_flag_n,
  input  logic              in_flag_c,
  input  logic              in_flag_v,
  output logic              rf_we,
  input  logic              rf_ready,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        status,
  output logic              busy
`ifdef WB_BYPASS_EN
  ,
  output logic              byp_valid,
  output logic [ADDR_W-1:0] byp_addr,
  output logic [DATA_W-1:0] byp_data
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] dest;
    logic              flag_we;
    logic              is_bitmanip;
    logic              z;
    logic              n;
    logic              c;
    logic              v;
  } entry_t;

  entry_t     mem [2];
  entry_t     head;
  entry_t     in_entry;
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       push;
  logic       pop;

  // Handshake, head presentation and entry packing from registered state only.
  always_comb begin
    in_ready = !rst && (count < 2'(DEPTH));
    push     = in_valid && in_ready && !flush;
    busy     = (count != 2'd0);
    rf_we    = busy;
    pop      = rf_we && rf_ready;
    head     = mem[rd_ptr];
    rf_waddr = rf_we ? head.dest   : '0;
    rf_wdata = rf_we ? head.result : '0;
    in_entry = '{result: in_result, dest: in_dest, flag_we: in_flag_we,
                 is_bitmanip: in_is_bitmanip, z: in_flag_z, n: in_flag_n,
                 c: in_flag_c, v: in_flag_v};
  end

  // Storage array; contents are only observed while counted as valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_entry;
  end

  // Occupancy and pointers; flush wins over any same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Status follows the retiring head; a pop under flush still commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      status <= '0;
    else if (pop && head.flag_we)
      status <= {head.n,
                 head.is_bitmanip ? 1'b0 : head.v,
                 head.is_bitmanip ? 1'b0 : head.c,
                 head.z};
  end

`ifdef WB_BYPASS_EN
  entry_t young;

  // Youngest entry sits just behind the write pointer (1-bit wrap).
  always_comb begin
    young     = mem[~wr_ptr];
    byp_valid = busy;
    byp_addr  = busy ? young.dest   : '0;
    byp_data  = busy ? young.result : '0;
  end
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: accepted results are queued with their
// flags, retires are compared against the queue head, and status is tracked
// by an independent model.
module tb_alu_writeback;

  typedef struct packed {
    logic [2:0] dest;
    logic [7:0] res;
    logic       fw;
    logic       bm;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_result = '0;
  logic [2:0] in_dest = '0;
  logic       in_flag_we = 1'b0;
  logic       in_is_bitmanip = 1'b0;
  logic       in_flag_z = 1'b0;
  logic       in_flag_n = 1'b0;
  logic       in_flag_c = 1'b0;
  logic       in_flag_v = 1'b0;
  logic       rf_we;
  logic       rf_ready = 1'b0;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [3:0] status;
  logic       busy;
`ifdef WB_BYPASS_EN
  logic       byp_valid;
  logic [2:0] byp_addr;
  logic [7:0] byp_data;
`endif

  ent_t       q[$];
  logic [3:0] st_model = '0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  alu_writeback #(.DATA_W(8), .ADDR_W(3), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_dest(in_dest), .in_flag_we(in_flag_we),
    .in_is_bitmanip(in_is_bitmanip), .in_flag_z(in_flag_z), .in_flag_n(in_flag_n),
    .in_flag_c(in_flag_c), .in_flag_v(in_flag_v), .rf_we(rf_we), .rf_ready(rf_ready),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .status(status), .busy(busy)
`ifdef WB_BYPASS_EN
    , .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] res, input logic [2:0] dest,
                       input logic fw, input logic bm, input logic z, input logic n,
                       input logic c, input logic ov);
    in_valid = v; in_result = res; in_dest = dest; in_flag_we = fw;
    in_is_bitmanip = bm; in_flag_z = z; in_flag_n = n; in_flag_c = c; in_flag_v = ov;
  endtask

  // One cycle: compare outputs mid-cycle, advance the model, cross the edge.
  task automatic step();
    ent_t e;
    logic retire;
    logic accept;
    @(negedge clk);
    check("in_ready", in_ready, !rst && (q.size() < 2));
    check("busy", busy, q.size() != 0);
    check("rf_we", rf_we, q.size() != 0);
    check("status", status, st_model);
    if (q.size() != 0) begin
      check("rf_waddr", rf_waddr, q[0].dest);
      check("rf_wdata", rf_wdata, q[0].res);
    end else begin
      check("rf_waddr_idle", rf_waddr, 0);
      check("rf_wdata_idle", rf_wdata, 0);
    end
`ifdef WB_BYPASS_EN
    check("byp_valid", byp_valid, q.size() != 0);
    check("byp_addr", byp_addr, (q.size() != 0) ? q[$].dest : 3'd0);
    check("byp_data", byp_data, (q.size() != 0) ? q[$].res : 8'd0);
`endif
    accept = !rst && in_valid && (q.size() < 2) && !flush;
    retire = !rst && (q.size() != 0) && rf_ready;
    if (retire) begin
      e = q.pop_front();
      if (e.fw) st_model = {e.n, e.bm ? 1'b0 : e.v, e.bm ? 1'b0 : e.c, e.z};
    end
    if (flush) q.delete();
    else if (accept)
      q.push_back('{dest: in_dest, res: in_result, fw: in_flag_we, bm: in_is_bitmanip,
                    z: in_flag_z, n: in_flag_n, c: in_flag_c, v: in_flag_v});
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for a few cycles, then released.
    repeat (3) step();
    rst = 1'b0;
    step();

    // 1: bit-manip op forces C,V clear at retire.
    rf_ready = 1'b1;
    drive(1, 8'h00, 3'd3, 1, 1, 1, 0, 1, 1);
    step();
    drive(0, 8'h00, 3'd0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    check("t1_status", status, 4'b0001);

    // 2: fill with rf_ready low; third offer is refused; then drain.
    rf_ready = 1'b0;
    drive(1, 8'h12, 3'd1, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, 8'h34, 3'd2, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, 8'h56, 3'd5, 1, 0, 0, 1, 0, 0);
    step();
    step();
    drive(0, 8'h00, 3'd0, 0, 0, 0, 0, 0, 0);
    rf_ready = 1'b1;
    repeat (3) step();

    // 3: back-to-back stream 0x80..0x84, N set on each.
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'h80 + 8'(i), 3'(i), 1, 0, 0, 1, i[0], 0);
      step();
    end
    drive(0, 8'h00, 3'd0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    check("t3_status_n", status[3], 1'b1);

    // 4: flush with two buffered; head retires and updates status.
    rf_ready = 1'b0;
    drive(1, 8'h11, 3'd4, 1, 0, 1, 0, 1, 0);
    step();
    drive(1, 8'h22, 3'd5, 1, 0, 0, 1, 0, 1);
    step();
    rf_ready = 1'b1;
    flush = 1'b1;
    drive(1, 8'h33, 3'd6, 1, 0, 0, 1, 1, 1);
    step();
    flush = 1'b0;
    drive(0, 8'h00, 3'd0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    check("t4_status", status, 4'b0011);

    // 5: async reset with two entries held.
    rf_ready = 1'b0;
    drive(1, 8'hC1, 3'd1, 1, 0, 0, 1, 0, 0);
    step();
    drive(1, 8'hC2, 3'd2, 1, 0, 0, 1, 0, 0);
    step();
    drive(0, 8'h00, 3'd0, 0, 0, 0, 0, 0, 0);
    rf_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("t5_rf_we", rf_we, 1'b0);
    check("t5_status", status, 4'b0000);
    check("t5_in_ready", in_ready, 1'b0);
    q.delete();
    st_model = '0;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();

    // 6: youngest-entry forwarding (byp_* checked inside step when enabled).
    rf_ready = 1'b0;
    drive(1, 8'h5A, 3'd4, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, 8'hA5, 3'd6, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 8'h00, 3'd0, 0, 0, 0, 0, 0, 0);
    step();
    rf_ready = 1'b1;
    step();
    rf_ready = 1'b0;
    step();
    rf_ready = 1'b1;
    repeat (2) step();

    // Random traffic with occasional flush.
    for (int i = 0; i < 80; i++) begin
      drive($urandom_range(0, 1) == 1, 8'($urandom), 3'($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      rf_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 11) == 0);
      step();
    end
    flush = 1'b0;
    drive(0, 8'h00, 3'd0, 0, 0, 0, 0, 0, 0);
    rf_ready = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
Writeback stage directly downstream of the ALU units, including the bit manipulation unit. Accepts one 8-bit result per cycle with its destination register and flags over a valid/ready handshake. Buffers up to 2 results in a small FIFO and retires them in order to the register-file write port. Maintains the architectural status register {N,V,C,Z}, which is updated only at retire.

Parameters:
DATA_W, 8, result/register width
ADDR_W, 3, register-file address width (8 registers)
DEPTH, 2, buffer entries; fixed at 2, other values unsupported

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous discard of all buffered entries
in_valid  input  1  upstream presents a result
in_ready  output  1  stage can accept; high when count<DEPTH
in_result  input  DATA_W  ALU result
in_dest  input  ADDR_W  destination register
in_flag_we  input  1  this op updates status
in_is_bitmanip  input  1  op from bit-manip unit; forces C=V=0 at retire
in_flag_z  input  1  zero flag from ALU
in_flag_n  input  1  negative flag from ALU
in_flag_c  input  1  carry flag (ignored if in_is_bitmanip)
in_flag_v  input  1  overflow flag (ignored if in_is_bitmanip)
rf_we  output  1  head entry valid; register-file write request
rf_ready  input  1  register file accepts write this cycle
rf_waddr  output  ADDR_W  head destination; 0 when empty
rf_wdata  output  DATA_W  head result; 0 when empty
status  output  4  {N,V,C,Z}, registered
busy  output  1  count!=0

Behaviour:
- Reset (async, rst=1): count=0, rd/wr pointers=0, status=4'b0000, rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, in_ready=0 while rst asserted, 1 the first cycle after release.
- Accept: push when in_valid && in_ready && !flush. Entry stores result, dest, flag_we, is_bitmanip, Z, N, C, V.
- in_ready depends only on registered count, never combinationally on rf_ready or in_valid.
- Retire: pop when rf_we && rf_ready. rf_we/rf_waddr/rf_wdata reflect the FIFO head combinationally from registered state. No combinational path exists from in_* to rf_*.
- Latency: entry accepted at edge N appears on rf_* in cycle N+1. Zero-bubble throughput of 1/cycle when rf_ready is held high.
- Status update happens at the retire edge only, and only if the head flag_we=1:
  - Z<=head Z, N<=head N.
  - C,V<=head C,V if is_bitmanip=0, else C<=0, V<=0.
  - If flag_we=0, status holds.
- Count rules:
  - push only: +1
  - pop only: -1
  - push and pop together at count=1: count stays 1; new entry becomes head next cycle.
  - At count=0, a push is not visible on rf_we until the next cycle; no same-cycle bypass.
- Full: count=2 forces in_ready=0. in_valid is ignored and upstream must hold its data.
- Empty: rf_we=0. rf_ready is ignored.
- Pointers: 1-bit pointers, wrap 1->0.
- Flush: highest priority. Next edge gives count=0 and pointers=0. A same-cycle push is dropped. A same-cycle pop still happens: if rf_we&&rf_ready the write completes and status updates from that head. Remaining entries never write and never touch status.
- Reset mid-operation: all entries are discarded immediately and no partial write is issued.

Optional Feature:
WB_BYPASS_EN
- Defined: adds output ports byp_valid (1), byp_addr (ADDR_W), byp_data (DATA_W). These present the youngest buffered entry (tail-1) for operand forwarding. byp_valid=busy. When count=2, the younger entry wins. All three are 0 on reset and when empty. They clear on the edge after flush.
- Undefined: these ports do not exist and the block contains no forwarding logic.

Test Plan:
1. Reset release, then push {result=0x00, dest=3, flag_we=1, bitmanip=1, Z=1, C=1, V=1} with rf_ready=1 -> rf_we=1, rf_waddr=3, rf_wdata=0x00 next cycle; status=4'b0001 after retire (C,V forced 0).
2. rf_ready=0, push 0x12->r1 then 0x34->r2 -> in_ready=0 after second accept and third in_valid is ignored; raise rf_ready -> writes r1=0x12 then r2=0x34 on consecutive cycles; busy falls the cycle after.
3. Continuous in_valid with rf_ready=1, 5 results 0x80..0x84 -> one write per cycle in order, no bubbles; status N=1 after each flagged retire.
4. Two entries buffered with rf_ready=1, assert flush for 1 cycle -> head write completes and updates status; second entry never appears on rf_we; count=0 next cycle.
5. Assert rst mid-stream with 2 entries held -> rf_we=0 and status=0000 immediately; no write issued after release.
6. (WB_BYPASS_EN) push 0x5A->r4 then 0xA5->r6 with rf_ready=0 -> byp_addr=6, byp_data=0xA5; after one retire and no push, byp shows r6 until it retires, then byp_valid=0.
